bf16_log2_core: RTL

BF16_LOG2_CORE -- requirements
Module: bf16_log2_core

---
 rtl/bf16_log2_core.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bf16_log2_core.sv
// ============================================================================
// Module      : bf16_log2_core
// Description : bfloat16 log2 by iterative squaring; integer part from the
//               exponent, fractional bits from repeated squaring of 1.man.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_log2_core #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 7,
    parameter int BIAS      = 127
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [EXP_WIDTH+MAN_WIDTH:0] data_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [EXP_WIDTH-1:0]         int_o,
    output logic [MAN_WIDTH-1:0]         frac_o,
    output logic                         err_o
);

    localparam int YW    = MAN_WIDTH + 1;
    localparam int PW    = 2 * YW;
    localparam int CNT_W = $clog2(MAN_WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SQUARE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [YW-1:0]          r_y;
    logic [EXP_WIDTH-1:0]   r_int;
    logic [MAN_WIDTH-2:0]   r_frac;

    logic                   w_sign;
    logic [EXP_WIDTH-1:0]   w_exp;
    logic [MAN_WIDTH-1:0]   w_man;
    logic                   w_invalid;
    logic [EXP_WIDTH-1:0]   w_int;
    logic [YW:0]            w_prod_hi;
    logic [MAN_WIDTH-1:0]   w_prod_unused;
    logic                   w_bit;
    logic [YW-1:0]          w_y_next;
    logic [MAN_WIDTH-1:0]   w_frac_next;

    assign w_sign    = data_i[EXP_WIDTH+MAN_WIDTH];
    assign w_exp     = data_i[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
    assign w_man     = data_i[MAN_WIDTH-1:0];
    // Any sign bit (including -0.0), zero/denormal or inf/NaN has no real log2
    assign w_invalid = w_sign | (w_exp == '0) | (w_exp == {EXP_WIDTH{1'b1}});
    assign w_int     = w_exp - EXP_WIDTH'(BIAS);

    // Only product bits [PW-1:MAN_WIDTH] feed the next Q1.7 operand
    assign {w_prod_hi, w_prod_unused} = {{YW{1'b0}}, r_y} * {{YW{1'b0}}, r_y};
    assign w_bit       = w_prod_hi[YW];
    assign w_y_next    = w_bit ? w_prod_hi[YW:1] : w_prod_hi[YW-1:0];
    assign w_frac_next = {r_frac, w_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_y     <= '0;
            r_int   <= '0;
            r_frac  <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            int_o   <= '0;
            frac_o  <= '0;
            err_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        ready_o <= 1'b0;
                        if (w_invalid) begin
                            int_o   <= {1'b1, {(EXP_WIDTH-1){1'b0}}};
                            frac_o  <= '0;
                            err_o   <= 1'b1;
                            valid_o <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_int   <= w_int;
                            r_y     <= {1'b1, w_man};
                            r_cnt   <= '0;
                            r_frac  <= '0;
                            r_state <= S_SQUARE;
                        end
                    end
                end
                S_SQUARE: begin
                    r_y    <= w_y_next;
                    r_frac <= w_frac_next[MAN_WIDTH-2:0];
                    if (r_cnt == C_LAST) begin
                        int_o   <= r_int;
                        frac_o  <= w_frac_next;
                        err_o   <= 1'b0;
                        valid_o <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
